lpc_req_sequencer: RTL and testbench
====================================

Name: lpc_req_sequencer

Overview:
Upstream command front-end for LPCHost. Queues LPC I/O requests (address, data, direction) from the TPM control logic in a request FIFO. Issues each request to LPCHost with a single-cycle start, tracks the host's ready/busy handshake with timeouts, and returns one response per request (read data plus error flag) through a response FIFO.

Parameters:
DEPTH, 4, entries in each of the request and response FIFOs (power of 2, ≥2)
ACK_WAIT, 4, max cycles after lpcStart for lpcReady to fall
TIMEOUT, 64, max cycles in WAIT_DONE before the transfer is declared failed

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
reqValid  in  1  upstream request valid
reqReady  out  1  request FIFO not full
reqAddr  in  16  LPC I/O address
reqData  in  8  write data (ignored for reads)
reqWrite  in  1  1=write, 0=read
rspValid  out  1  response FIFO not empty
rspReady  in  1  downstream accepts response
rspData  out  8  read data (0x00 for writes and errors)
rspWrite  out  1  direction of completed request
rspErr  out  1  ack or done timeout occurred
lpcAddr  out  16  to LPCHost addr
lpcData  out  8  to LPCHost inData
lpcIsWrite  out  1  to LPCHost isWrite
lpcStart  out  1  to LPCHost start, one-cycle pulse
lpcReady  in  1  from LPCHost isReady
lpcRdData  in  8  from LPCHost outData
busy  out  1  FSM not in IDLE
reqCount  out  $clog2(DEPTH+1)  request FIFO occupancy

Behaviour:
- Reset (reset=0, async): FIFOs emptied, FSM→IDLE, timers cleared.
  - Reset values: reqReady=1, rspValid=0, rspData=0, rspWrite=0, rspErr=0, lpcAddr=0, lpcData=0, lpcIsWrite=0, lpcStart=0, busy=0, reqCount=0.
  - Reset mid-transfer drops lpcStart immediately and discards all queued requests and responses.
- Request FIFO:
  - reqReady = !full, registered; there is no combinational path from rspReady or lpcReady.
  - A push occurs when reqValid&&reqReady.
  - Simultaneous push and pop are legal, including when full (reqReady is still 0 when full, so no push then).
  - Pointers wrap mod DEPTH.
- Response FIFO:
  - Standard valid/ready; a pop occurs when rspValid&&rspReady.
  - rspData, rspWrite and rspErr present the head entry and are stable while rspValid=1 and rspReady=0.
- FSM states:
  - IDLE: go to ISSUE when request FIFO non-empty AND response FIFO not full AND lpcReady=1. Otherwise hold.
  - ISSUE: lpcStart=1 for exactly this cycle. lpcAddr, lpcData and lpcIsWrite are registered from the FIFO head on IDLE→ISSUE and held until the next ISSUE. Next state is WAIT_ACK.
  - WAIT_ACK: lpcReady=0 → WAIT_DONE. If lpcReady is still 1 after ACK_WAIT cycles → PUSH with err=1.
  - WAIT_DONE: the counter starts at 0 on entry. lpcReady=1 → capture lpcRdData (reads) or 0x00 (writes), err=0, then PUSH. If the counter reaches TIMEOUT with lpcReady still 0 → PUSH with err=1, data=0x00.
  - PUSH: write {data, write, err} into the response FIFO, pop the request FIFO, go to IDLE.
- Latency: a request accepted into an empty FIFO at edge N, with lpcReady=1, gives lpcStart high in cycle N+2. Completion gives rspValid one cycle after PUSH.
- Reserving a response slot before ISSUE guarantees PUSH never sees a full response FIFO.
- After a timeout the host may still be busy. IDLE's lpcReady=1 condition blocks further issues until the host recovers.
- Requests complete strictly in order; there is at most one outstanding LPC transfer.
- busy=1 in every state except IDLE.

Test Plan:
1. Reset, push write 0x1234/0xAB. Model drops lpcReady 1 cycle after start and raises it 12 cycles later → one lpcStart pulse with lpcAddr=0x1234, lpcData=0xAB, lpcIsWrite=1; response {rspWrite=1, rspErr=0, rspData=0x00}.
2. Push read 0x8765; model returns 0x5A on lpcRdData when lpcReady rises → lpcIsWrite=0, response {rspWrite=0, rspErr=0, rspData=0x5A}.
3. Hold lpcReady=0 and push 5 requests → reqReady=0 and reqCount=4 after the 4th; no lpcStart. Raise lpcReady → 4 transfers issued in push order, 4 ordered responses; the 5th accepted once space frees.
4. rspReady=0 with 6 reads queued → exactly 4 lpcStart pulses, FSM parks in IDLE. Assert rspReady → remaining 2 issue, 6 responses drained in order.
5. Model never re-raises lpcReady → response with rspErr=1, rspData=0x00 exactly TIMEOUT=64 cycles after WAIT_DONE entry; no new lpcStart until lpcReady=1. Model never drops lpcReady → rspErr=1 after ACK_WAIT=4 cycles.
6. Assert reset during WAIT_DONE with 2 requests queued → lpcStart=0, rspValid=0, reqCount=0, reqReady=1 immediately; a fresh request after release completes normally.

Source files
------------

// File: rtl/lpc_req_sequencer.sv
// Request/response sequencer in front of LPCHost: queues I/O requests, issues them
// one at a time with start/ready handshaking and timeouts, and queues one response each.
module lpc_req_sequencer #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ACK_WAIT = 4,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       reqValid,
  output logic                       reqReady,
  input  logic [15:0]                reqAddr,
  input  logic [7:0]                 reqData,
  input  logic                       reqWrite,
  output logic                       rspValid,
  input  logic                       rspReady,
  output logic [7:0]                 rspData,
  output logic                       rspWrite,
  output logic                       rspErr,
  output logic [15:0]                lpcAddr,
  output logic [7:0]                 lpcData,
  output logic                       lpcIsWrite,
  output logic                       lpcStart,
  input  logic                       lpcReady,
  input  logic [7:0]                 lpcRdData,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] reqCount
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CW   = $clog2(DEPTH+1);
  localparam int unsigned TMAX = (TIMEOUT > ACK_WAIT) ? TIMEOUT : ACK_WAIT;
  localparam int unsigned TW   = $clog2(TMAX+1);
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [TW-1:0] ACK_LAST  = TW'(ACK_WAIT-1);
  localparam logic [TW-1:0] DONE_LAST = TW'(TIMEOUT-1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE, PUSH} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [AW-1:0]   req_wr_q, req_wr_d, req_rd_q, req_rd_d;
  logic [AW-1:0]   rsp_wr_q, rsp_wr_d, rsp_rd_q, rsp_rd_d;
  logic [CW-1:0]   req_cnt_q, req_cnt_d, rsp_cnt_q, rsp_cnt_d;
  logic            req_ready_q, req_ready_d;
  logic [15:0]     lpc_addr_q, lpc_addr_d;
  logic [7:0]      lpc_data_q, lpc_data_d;
  logic            lpc_wr_q, lpc_wr_d;
  logic            lpc_start_q, lpc_start_d;
  logic [7:0]      rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic            busy_q, busy_d;

  // Entries: request {addr, data, write}, response {data, write, err}
  logic [24:0]     req_mem_q [DEPTH];
  logic [9:0]      rsp_mem_q [DEPTH];

  logic [24:0]     req_head;
  logic [9:0]      rsp_head;
  logic            req_push, rsp_pop, rsp_valid, fsm_push;

  assign req_head  = req_mem_q[req_rd_q];
  assign rsp_head  = rsp_mem_q[rsp_rd_q];
  assign req_push  = reqValid && req_ready_q;
  assign rsp_valid = (rsp_cnt_q != '0);
  assign rsp_pop   = rsp_valid && rspReady;
  assign fsm_push  = (state_q == PUSH);

  always_comb begin
    req_wr_d  = req_push ? req_wr_q + 1'b1 : req_wr_q;
    req_rd_d  = fsm_push ? req_rd_q + 1'b1 : req_rd_q;
    req_cnt_d = req_cnt_q;
    if (req_push && !fsm_push)      req_cnt_d = req_cnt_q + 1'b1;
    else if (!req_push && fsm_push) req_cnt_d = req_cnt_q - 1'b1;
    req_ready_d = (req_cnt_d != FULL);

    rsp_wr_d  = fsm_push ? rsp_wr_q + 1'b1 : rsp_wr_q;
    rsp_rd_d  = rsp_pop ? rsp_rd_q + 1'b1 : rsp_rd_q;
    rsp_cnt_d = rsp_cnt_q;
    if (fsm_push && !rsp_pop)      rsp_cnt_d = rsp_cnt_q + 1'b1;
    else if (!fsm_push && rsp_pop) rsp_cnt_d = rsp_cnt_q - 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    lpc_addr_d = lpc_addr_q;
    lpc_data_d = lpc_data_q;
    lpc_wr_d   = lpc_wr_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        // At most one transfer in flight, so a free response slot now stays free until PUSH
        if ((req_cnt_q != '0) && (rsp_cnt_q != FULL) && lpcReady) begin
          state_d    = ISSUE;
          lpc_addr_d = req_head[24:9];
          lpc_data_d = req_head[8:1];
          lpc_wr_d   = req_head[0];
        end
      end
      ISSUE: begin
        state_d = WAIT_ACK;
        tmr_d   = '0;
      end
      WAIT_ACK: begin
        if (!lpcReady) begin
          state_d = WAIT_DONE;
          tmr_d   = '0;
        end else if (tmr_q == ACK_LAST) begin
          state_d    = PUSH;
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (lpcReady) begin
          state_d    = PUSH;
          rsp_data_d = lpc_wr_q ? 8'h00 : lpcRdData;
          rsp_err_d  = 1'b0;
        end else if (tmr_q == DONE_LAST) begin
          state_d    = PUSH;
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      PUSH:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    lpc_start_d = (state_d == ISSUE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      tmr_q       <= '0;
      req_wr_q    <= '0;
      req_rd_q    <= '0;
      req_cnt_q   <= '0;
      req_ready_q <= 1'b1;
      rsp_wr_q    <= '0;
      rsp_rd_q    <= '0;
      rsp_cnt_q   <= '0;
      lpc_addr_q  <= '0;
      lpc_data_q  <= '0;
      lpc_wr_q    <= 1'b0;
      lpc_start_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        req_mem_q[i] <= '0;
        rsp_mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      req_wr_q    <= req_wr_d;
      req_rd_q    <= req_rd_d;
      req_cnt_q   <= req_cnt_d;
      req_ready_q <= req_ready_d;
      rsp_wr_q    <= rsp_wr_d;
      rsp_rd_q    <= rsp_rd_d;
      rsp_cnt_q   <= rsp_cnt_d;
      lpc_addr_q  <= lpc_addr_d;
      lpc_data_q  <= lpc_data_d;
      lpc_wr_q    <= lpc_wr_d;
      lpc_start_q <= lpc_start_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      if (req_push) req_mem_q[req_wr_q] <= {reqAddr, reqData, reqWrite};
      if (fsm_push) rsp_mem_q[rsp_wr_q] <= {rsp_data_q, lpc_wr_q, rsp_err_q};
    end
  end

  assign reqReady   = req_ready_q;
  assign rspValid   = rsp_valid;
  assign rspData    = rsp_head[9:2];
  assign rspWrite   = rsp_head[1];
  assign rspErr     = rsp_head[0];
  assign lpcAddr    = lpc_addr_q;
  assign lpcData    = lpc_data_q;
  assign lpcIsWrite = lpc_wr_q;
  assign lpcStart   = lpc_start_q;
  assign busy       = busy_q;
  assign reqCount   = req_cnt_q;

endmodule

// File: tb/tb_lpc_req_sequencer.sv
// Directed bench for lpc_req_sequencer with a behavioural LPCHost responder and
// issue/response scoreboards.
module tb_lpc_req_sequencer;

  localparam int DEPTH    = 4;
  localparam int ACK_WAIT = 4;
  localparam int TIMEOUT  = 64;
  localparam int BUSY     = 12;

  typedef enum int {M_NORMAL, M_NO_DROP, M_NO_RAISE} mode_e;

  logic        clk, reset;
  logic        reqValid, reqReady, reqWrite;
  logic [15:0] reqAddr;
  logic [7:0]  reqData;
  logic        rspValid, rspReady, rspWrite, rspErr;
  logic [7:0]  rspData;
  logic [15:0] lpcAddr;
  logic [7:0]  lpcData, lpcRdData;
  logic        lpcIsWrite, lpcStart, lpcReady, busy;
  logic [2:0]  reqCount;

  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc = 0;
  int    start_cnt = 0;
  int    start_cyc = 0;
  int    drop_cyc = 0;
  int    rsp_cyc = 0;
  logic  host_up;
  logic  stuck;
  mode_e host_mode;

  logic [24:0] exp_iss[$];
  logic [9:0]  exp_rsp[$];

  lpc_req_sequencer #(.DEPTH(DEPTH), .ACK_WAIT(ACK_WAIT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .reqValid(reqValid), .reqReady(reqReady), .reqAddr(reqAddr), .reqData(reqData),
    .reqWrite(reqWrite),
    .rspValid(rspValid), .rspReady(rspReady), .rspData(rspData), .rspWrite(rspWrite),
    .rspErr(rspErr),
    .lpcAddr(lpcAddr), .lpcData(lpcData), .lpcIsWrite(lpcIsWrite), .lpcStart(lpcStart),
    .lpcReady(lpcReady), .lpcRdData(lpcRdData),
    .busy(busy), .reqCount(reqCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] rd_fn(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hB8;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Host model: holds ready low for BUSY cycles per transfer, or misbehaves per host_mode
  initial begin : host
    logic [15:0] a;
    logic [24:0] e;
    lpcReady  = 1'b1;
    lpcRdData = '0;
    stuck     = 1'b0;
    forever begin
      step();
      if (host_mode != M_NO_RAISE) stuck = 1'b0;
      if (lpcStart) begin
        start_cnt++;
        start_cyc = cyc;
        check("issue_expected", 32'(exp_iss.size() != 0), 32'd1);
        if (exp_iss.size() != 0) begin
          e = exp_iss.pop_front();
          check("issue_fields", 32'({lpcAddr, lpcData, lpcIsWrite}), 32'(e));
        end
        a = lpcAddr;
        if (host_mode != M_NO_DROP) begin
          step();
          lpcReady = 1'b0;
          drop_cyc = cyc;
          if (host_mode == M_NORMAL) begin
            repeat (BUSY) step();
            lpcRdData = rd_fn(a);
            lpcReady  = 1'b1;
          end else begin
            stuck = 1'b1;
          end
        end
      end else begin
        lpcReady = host_up && !stuck;
      end
    end
  end

  initial begin : rsp_monitor
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (reset && rspValid && rspReady) begin
        rsp_cyc = cyc;
        check("rsp_expected", 32'(exp_rsp.size() != 0), 32'd1);
        if (exp_rsp.size() != 0) begin
          e = exp_rsp.pop_front();
          check("rsp_fields", 32'({rspWrite, rspErr, rspData}), 32'(e));
        end
      end
    end
  end

  // Waits for the currently driven request to be accepted, then records its expectations
  task automatic accept_wait(input logic err);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 400) begin
      @(negedge clk);
      if (reqReady) begin
        acc = 1'b1;
        exp_iss.push_back({reqAddr, reqData, reqWrite});
        exp_rsp.push_back({reqWrite, err, (reqWrite || err) ? 8'h00 : rd_fn(reqAddr)});
      end
      step();
      n++;
    end
    reqValid = 1'b0;
    check("req_accepted", 32'(acc), 32'd1);
  endtask

  task automatic send(input logic [15:0] a, input logic [7:0] d, input logic w, input logic err);
    reqValid = 1'b1;
    reqAddr  = a;
    reqData  = d;
    reqWrite = w;
    accept_wait(err);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_rsp.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check("drain", 32'(exp_rsp.size()), 32'd0);
  endtask

  initial begin : stim
    int s0;
    int n;
    reset = 1'b0; reqValid = 1'b0; reqAddr = '0; reqData = '0; reqWrite = 1'b0;
    rspReady = 1'b1; host_up = 1'b1; host_mode = M_NORMAL;
    repeat (3) step();
    check("rst_reqReady", 32'(reqReady), 32'd1);
    check("rst_rspValid", 32'(rspValid), 32'd0);
    check("rst_rspData", 32'(rspData), 32'd0);
    check("rst_rspWrite", 32'(rspWrite), 32'd0);
    check("rst_rspErr", 32'(rspErr), 32'd0);
    check("rst_lpcAddr", 32'(lpcAddr), 32'd0);
    check("rst_lpcData", 32'(lpcData), 32'd0);
    check("rst_lpcIsWrite", 32'(lpcIsWrite), 32'd0);
    check("rst_lpcStart", 32'(lpcStart), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_reqCount", 32'(reqCount), 32'd0);
    reset = 1'b1;
    step();

    // Single write, then single read
    s0 = start_cnt;
    send(16'h1234, 8'hAB, 1'b1, 1'b0);
    repeat (4) step();
    check("t1_busy", 32'(busy), 32'd1);
    wait_drain(300);
    check("t1_starts", 32'(start_cnt - s0), 32'd1);
    send(16'h8765, 8'h00, 1'b0, 1'b0);
    wait_drain(300);

    // Host not ready: fill request FIFO, then release
    host_up = 1'b0;
    repeat (2) step();
    s0 = start_cnt;
    for (int i = 0; i < 4; i++) send(16'h1000 + 16'(i), 8'h10 + 8'(i), i[0], 1'b0);
    @(negedge clk);
    check("t3_full_ready", 32'(reqReady), 32'd0);
    check("t3_full_count", 32'(reqCount), 32'd4);
    step();
    reqValid = 1'b1; reqAddr = 16'h1004; reqData = 8'h14; reqWrite = 1'b0;
    repeat (10) step();
    check("t3_still_full", 32'(reqReady), 32'd0);
    check("t3_no_start", 32'(start_cnt - s0), 32'd0);
    host_up = 1'b1;
    accept_wait(1'b0);
    wait_drain(600);
    check("t3_starts", 32'(start_cnt - s0), 32'd5);

    // Response back-pressure: at most DEPTH transfers outstanding in the response FIFO
    rspReady = 1'b0;
    s0 = start_cnt;
    for (int i = 0; i < 6; i++) send(16'h4000 + 16'(i), 8'h00, 1'b0, 1'b0);
    repeat (150) step();
    check("t4_parked_starts", 32'(start_cnt - s0), 32'd4);
    check("t4_parked_idle", 32'(busy), 32'd0);
    check("t4_parked_count", 32'(reqCount), 32'd2);
    check("t4_rspValid", 32'(rspValid), 32'd1);
    check("t4_head_stable", 32'(rspData), 32'(exp_rsp[0][7:0]));
    rspReady = 1'b1;
    wait_drain(600);
    check("t4_starts", 32'(start_cnt - s0), 32'd6);

    // Done timeout; host stays busy afterwards
    host_mode = M_NO_RAISE;
    send(16'h0042, 8'h00, 1'b0, 1'b1);
    wait_drain(300);
    // WAIT_DONE is entered on the edge after the drop; response visible after PUSH
    check("t5_done_latency", 32'(rsp_cyc - drop_cyc), 32'(TIMEOUT + 2));
    s0 = start_cnt;
    send(16'h0043, 8'h00, 1'b0, 1'b0);
    repeat (20) step();
    check("t5_blocked", 32'(start_cnt - s0), 32'd0);
    host_mode = M_NORMAL;
    wait_drain(300);
    check("t5_recovered", 32'(start_cnt - s0), 32'd1);

    // Ack timeout: host never drops ready
    host_mode = M_NO_DROP;
    send(16'h0050, 8'h11, 1'b1, 1'b1);
    wait_drain(300);
    check("t5_ack_latency", 32'(rsp_cyc - start_cyc), 32'(ACK_WAIT + 2));
    host_mode = M_NORMAL;
    repeat (3) step();

    // Reset mid-transfer with requests queued
    s0 = start_cnt;
    send(16'h2000, 8'h00, 1'b0, 1'b0);
    send(16'h2001, 8'h21, 1'b1, 1'b0);
    send(16'h2002, 8'h00, 1'b0, 1'b0);
    n = 0;
    while (start_cnt == s0 && n < 50) begin
      step();
      n++;
    end
    check("t6_started", 32'(start_cnt - s0), 32'd1);
    repeat (5) step();
    reset = 1'b0;
    #1;
    check("t6_lpcStart", 32'(lpcStart), 32'd0);
    check("t6_rspValid", 32'(rspValid), 32'd0);
    check("t6_reqCount", 32'(reqCount), 32'd0);
    check("t6_reqReady", 32'(reqReady), 32'd1);
    check("t6_busy", 32'(busy), 32'd0);
    exp_iss.delete();
    exp_rsp.delete();
    repeat (3) step();
    reset = 1'b1;
    step();
    send(16'h3000, 8'h77, 1'b1, 1'b0);
    wait_drain(300);
    check("t6_after_count", 32'(reqCount), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
